// File: rtl/calc_entry_ctrl.sv
// Keypad entry sequencer: turns debounced key presses into BCD-register commands
// and operand/operator/execute strobes for the ALU stage.
module calc_entry_ctrl #(
   parameter int MAX_DIGITS = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] key,
   input  logic       key_valid,
   output logic [3:0] digit,
   output logic       load,
   output logic       bksp,
   output logic       clear,
   output logic       store_a,
   output logic       store_b,
   output logic [1:0] op,
   output logic       exec,
   output logic [1:0] state,
   output logic [1:0] digit_count,
   output logic       busy
);

   localparam logic [1:0] ST_ENTER_A = 2'd0;
   localparam logic [1:0] ST_ENTER_B = 2'd1;
   localparam logic [1:0] ST_RESULT  = 2'd2;
   localparam logic [1:0] ST_EXEC    = 2'd3;

   localparam logic [1:0] NX_NONE  = 2'd0;
   localparam logic [1:0] NX_LOAD  = 2'd1;
   localparam logic [1:0] NX_CLEAR = 2'd2;
   localparam logic [1:0] NX_EXEC  = 2'd3;

   localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

   logic       kv_q, kv_d;
   logic       armed_q, armed_d;
   logic [1:0] state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] op_q, op_d;
   logic [3:0] digit_q, digit_d;
   logic [1:0] nxt_q, nxt_d;
   logic       load_q, load_d;
   logic       bksp_q, bksp_d;
   logic       clear_q, clear_d;
   logic       store_a_q, store_a_d;
   logic       store_b_q, store_b_d;
   logic       exec_q, exec_d;
   logic       busy_q, busy_d;

   logic       press;
   logic [3:0] op_sel;

   // armed_q blocks a key still held through reset from counting as a fresh press
   always_comb begin
      kv_d      = key_valid;
      armed_d   = armed_q | ~key_valid;
      press     = key_valid & ~kv_q & armed_q;
      op_sel    = key - 4'd10;
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      digit_d   = digit_q;
      nxt_d     = NX_NONE;
      load_d    = 1'b0;
      bksp_d    = 1'b0;
      clear_d   = 1'b0;
      store_a_d = 1'b0;
      store_b_d = 1'b0;
      exec_d    = 1'b0;
      busy_d    = 1'b0;

      if (press && key == 4'd15) begin
         clear_d = 1'b1;
         state_d = ST_ENTER_A;
         cnt_d   = 2'd0;
         op_d    = 2'd0;
      end else if (nxt_q != NX_NONE) begin
         // Second half of a two-cycle command; other presses are dropped here
         case (nxt_q)
            NX_LOAD: begin
               load_d  = 1'b1;
               state_d = ST_ENTER_A;
               cnt_d   = 2'd1;
            end
            NX_CLEAR: begin
               clear_d = 1'b1;
               state_d = ST_ENTER_B;
               cnt_d   = 2'd0;
            end
            default: begin
               exec_d  = 1'b1;
               state_d = ST_RESULT;
               cnt_d   = 2'd0;
            end
         endcase
      end else if (press) begin
         case (state_q)
            ST_ENTER_A, ST_ENTER_B: begin
               if (key <= 4'd9) begin
                  if (cnt_q < MAX_CNT) begin
                     load_d  = 1'b1;
                     digit_d = key;
                     cnt_d   = cnt_q + 2'd1;
                  end
               end else if (key == 4'd14) begin
                  if (cnt_q != 2'd0) begin
                     bksp_d = 1'b1;
                     cnt_d  = cnt_q - 2'd1;
                  end
               end else if (key <= 4'd12) begin
                  if (state_q == ST_ENTER_A && cnt_q != 2'd0) begin
                     store_a_d = 1'b1;
                     op_d      = op_sel[1:0];
                     busy_d    = 1'b1;
                     nxt_d     = NX_CLEAR;
                  end else if (state_q == ST_ENTER_B && cnt_q == 2'd0) begin
                     op_d = op_sel[1:0];
                  end
               end else if (key == 4'd13) begin
                  if (state_q == ST_ENTER_B && cnt_q != 2'd0) begin
                     store_b_d = 1'b1;
                     state_d   = ST_EXEC;
                     busy_d    = 1'b1;
                     nxt_d     = NX_EXEC;
                  end
               end
            end
            ST_RESULT: begin
               if (key <= 4'd9) begin
                  clear_d = 1'b1;
                  digit_d = key;
                  busy_d  = 1'b1;
                  nxt_d   = NX_LOAD;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         kv_q      <= 1'b0;
         armed_q   <= 1'b0;
         state_q   <= ST_ENTER_A;
         cnt_q     <= 2'd0;
         op_q      <= 2'd0;
         digit_q   <= 4'd0;
         nxt_q     <= NX_NONE;
         load_q    <= 1'b0;
         bksp_q    <= 1'b0;
         clear_q   <= 1'b0;
         store_a_q <= 1'b0;
         store_b_q <= 1'b0;
         exec_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         kv_q      <= kv_d;
         armed_q   <= armed_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         digit_q   <= digit_d;
         nxt_q     <= nxt_d;
         load_q    <= load_d;
         bksp_q    <= bksp_d;
         clear_q   <= clear_d;
         store_a_q <= store_a_d;
         store_b_q <= store_b_d;
         exec_q    <= exec_d;
         busy_q    <= busy_d;
      end
   end

   assign digit       = digit_q;
   assign load        = load_q;
   assign bksp        = bksp_q;
   assign clear       = clear_q;
   assign store_a     = store_a_q;
   assign store_b     = store_b_q;
   assign op          = op_q;
   assign exec        = exec_q;
   assign state       = state_q;
   assign digit_count = cnt_q;
   assign busy        = busy_q;

endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
Keypad entry sequencer for the calculator front end. It turns debounced key codes into single-cycle load/bksp/clear/digit commands for the 3-digit BCD entry register. It tracks how many digits have been entered and walks the operand A -> operator -> operand B -> '=' sequence. It emits operand-latch, operator and execute strobes to the ALU stage.

Parameters:
MAX_DIGITS, 3, maximum digits per operand (legal 1..3); digit keys beyond this are ignored

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
key  in  4  debounced key code: 0-9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14 backspace, 15 clear
key_valid  in  1  level, high while a key is held; key stable whenever key_valid=1
digit  out  4  digit value to the BCD register, valid with load
load  out  1  1-cycle pulse: shift digit into the BCD register
bksp  out  1  1-cycle pulse: drop the least-significant digit
clear  out  1  1-cycle pulse: blank the BCD register
store_a  out  1  1-cycle pulse: ALU latches the displayed value as operand A
store_b  out  1  1-cycle pulse: ALU latches the displayed value as operand B
op  out  2  latched operator: 0 add, 1 sub, 2 mul
exec  out  1  1-cycle pulse: ALU computes op(A,B)
state  out  2  0 ENTER_A, 1 ENTER_B, 2 RESULT, 3 EXEC (internal)
digit_count  out  2  digits currently entered in the active operand
busy  out  1  high during a multi-cycle command sequence

Behaviour:
- Reset (async, reset_n=0): state=ENTER_A, digit_count=0, op=0, digit=0, all pulses 0, busy=0, edge register=0.
- Press detection: key_valid is registered into kv_q. A press is the cycle where key_valid=1 and kv_q=0, and key is sampled that cycle. Holding a key gives exactly one press.
- Command outputs are registered and assert the cycle after the press is detected (latency 1). All pulses are exactly 1 cycle.
- Digit key (0-9):
  - ENTER_A/ENTER_B with digit_count<MAX_DIGITS: load=1, digit=key, digit_count+1.
  - ENTER_A/ENTER_B with digit_count==MAX_DIGITS: no output.
  - RESULT: clear=1 in cycle +1, then load=1 with digit=key in cycle +2. busy=1 for cycle +1. Then digit_count=1, state=ENTER_A.
- Backspace (14): if digit_count>0, bksp=1 and digit_count-1. If digit_count=0, no output. In RESULT: ignored.
- Operator (10-12):
  - ENTER_A with digit_count>0: store_a=1 and op latched in cycle +1; clear=1 in cycle +2 (busy=1 cycle +1). Then state=ENTER_B, digit_count=0.
  - ENTER_A with digit_count=0: ignored.
  - ENTER_B with digit_count=0: op replaced only, no pulses.
  - ENTER_B with digit_count>0, or RESULT: ignored.
- '=' (13):
  - ENTER_B with digit_count>0: store_b=1 in cycle +1 (state EXEC, busy=1); exec=1 in cycle +2. Then state=RESULT, digit_count=0. op holds its value.
  - Anywhere else: ignored.
- Clear (15), any state including EXEC: clear=1 in cycle +1; state=ENTER_A, digit_count=0, op=0. Clear aborts a pending second cycle: no exec or load follows.
- Presses other than clear detected while busy=1 are dropped. kv_q still updates, so a held key does not re-fire after busy drops.
- At most one of load/bksp/clear/store_a/store_b/exec is high in any cycle.
- digit_count never exceeds MAX_DIGITS and never underflows.
- Reset asserted mid-sequence clears everything immediately. After reset_n rises, no pulses occur until a new press.

Test Plan:
- Reset, press 1,2,3,4 (each held 5 cycles) -> three load pulses with digit=1,2,3; the fourth press produces nothing; digit_count=3; each load appears exactly 1 cycle after the rising edge.
- From ENTER_A with digit_count=2, press 14 three times -> two bksp pulses, third press silent, digit_count=0.
- Enter 1,2, '+', then '-', then 5, '=' -> store_a then clear on the next cycle; op=0 then 1; load digit=5; store_b then exec on the next cycle; state=RESULT, op=1.
- In RESULT press 7 -> clear then load digit=7 on consecutive cycles; state=ENTER_A, digit_count=1.
- Press '=' and then clear on the cycle store_b asserts -> no exec; clear pulse; state=ENTER_A, op=0.
- Hold key 3 for 50 cycles, then pulse reset_n low mid-hold and release -> a single load before reset; all outputs 0 during reset; no load after release while the key is still held.
